// File: rtl/stft_frame_sched.sv
// ============================================================================
// Module      : stft_frame_sched
// Description : Buffers the audio sample stream in a ring buffer, launches
//               overlapping STFT frames, streams each frame to the stft core
//               and forwards the returned coefficients with an index.
//               Optional done/coefficient watchdog: STFT_SCHED_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stft_frame_sched #(
    parameter int DW        = 16,
    parameter int CW        = 28,
    parameter int FRAME_LEN = 2048,
    parameter int HOP       = 512,
    parameter int DEPTH     = 4096,
    parameter int NUM_COEFF = 180
`ifdef STFT_SCHED_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 65536
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          samp_valid,
    input  logic [DW-1:0] samp_data,
    output logic          samp_ready,
    output logic          stft_full,
    output logic [DW-1:0] stft_datum,
    input  logic          stft_done,
    input  logic          stft_ready,
    input  logic [CW-1:0] stft_coeff,
    output logic          coeff_valid,
    output logic [CW-1:0] coeff_data,
    output logic [7:0]    coeff_idx,
    output logic          frame_done,
    output logic [15:0]   frame_cnt,
    output logic          busy
`ifdef STFT_SCHED_WDOG_EN
    ,
    output logic          err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int FW = $clog2(FRAME_LEN + 1);

    localparam logic [PW-1:0] c_depth       = PW'(DEPTH);
    localparam logic [PW-1:0] c_frame_len   = PW'(FRAME_LEN);
    localparam logic [PW-1:0] c_hop         = PW'(HOP);
    localparam logic [FW-1:0] c_stream_last = FW'(FRAME_LEN - 1);
    localparam logic [7:0]    c_coeff_last  = 8'(NUM_COEFF - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_STREAM    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_COLLECT   = 3'd4,
        S_RETIRE    = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_base;
    logic [PW-1:0]   w_pending;
    logic            r_live;
    logic            w_wr;

    logic [FW-1:0]   r_k;
    logic [FW-1:0]   w_rd_off;
    logic [AW-1:0]   w_rd_addr;
    logic            w_rd_en;
    logic [DW-1:0]   r_datum;

    logic            r_ready_q;
    logic            w_edge;
    logic [7:0]      r_ccnt;
    logic            r_coeff_valid;
    logic [CW-1:0]   r_coeff_data;
    logic [7:0]      r_coeff_idx;

    logic            r_full;
    logic            r_frame_done;
    logic            r_busy;
    logic [15:0]     r_frame_cnt;
    logic            w_wdog_fire;

    // Ring occupancy: modulo difference of the extended pointers.
    assign w_pending  = r_wr_ptr - r_rd_base;
    assign samp_ready = r_live & (w_pending < c_depth);
    assign w_wr       = samp_valid & samp_ready;

    // LAUNCH prefetches sample 0; each STREAM cycle k fetches sample k+1.
    assign w_rd_off  = (r_state == S_LAUNCH) ? '0 : (r_k + FW'(1));
    assign w_rd_addr = r_rd_base[AW-1:0] + AW'(w_rd_off);
    assign w_rd_en   = (r_state == S_LAUNCH) ||
                       ((r_state == S_STREAM) && (r_k != c_stream_last));

    assign w_edge = (r_state == S_COLLECT) & stft_ready & ~r_ready_q;

`ifdef STFT_SCHED_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] r_wdog;
    logic          r_err;
    logic          w_wdog_hit;

    assign w_wdog_hit = ((r_state == S_WAIT_DONE) || (r_state == S_COLLECT)) &&
                        (r_wdog == WW'(WDOG_CYCLES - 1));
    // Real progress in the same cycle takes priority over the timeout.
    assign w_wdog_fire = w_wdog_hit & ~w_edge &
                         ~((r_state == S_WAIT_DONE) & stft_done);
    assign err = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (((r_state != S_WAIT_DONE) && (r_state != S_COLLECT)) ||
                (w_state_nxt != r_state) || w_edge) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + WW'(1);
            end
            if (w_wdog_fire) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_wdog_fire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (en && (w_pending >= c_frame_len)) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (r_k == c_stream_last) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (stft_done) begin
                    w_state_nxt = S_COLLECT;
                end else if (w_wdog_fire) begin
                    w_state_nxt = S_RETIRE;
                end
            end
            S_COLLECT: begin
                if (w_edge && (r_ccnt == c_coeff_last)) begin
                    w_state_nxt = S_RETIRE;
                end else if (w_wdog_fire) begin
                    w_state_nxt = S_RETIRE;
                end
            end
            S_RETIRE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sample storage; the frame window is protected by the pending < DEPTH gate.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= samp_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_base     <= '0;
            r_live        <= 1'b0;
            r_k           <= '0;
            r_datum       <= '0;
            r_ready_q     <= 1'b0;
            r_ccnt        <= '0;
            r_coeff_valid <= 1'b0;
            r_coeff_data  <= '0;
            r_coeff_idx   <= '0;
            r_full        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end

            if (r_state == S_LAUNCH) begin
                r_k <= '0;
            end else if (r_state == S_STREAM) begin
                r_k <= r_k + FW'(1);
            end
            if (w_rd_en) begin
                r_datum <= r_mem[w_rd_addr];
            end

            // Previous-level register is held low outside COLLECT so a level
            // already high on entry counts as the first edge.
            r_ready_q     <= (r_state == S_COLLECT) ? stft_ready : 1'b0;
            r_coeff_valid <= w_edge;
            if (r_state != S_COLLECT) begin
                r_ccnt <= '0;
            end else if (w_edge) begin
                r_ccnt       <= r_ccnt + 8'd1;
                r_coeff_data <= stft_coeff;
                r_coeff_idx  <= r_ccnt;
            end

            if (r_state == S_RETIRE) begin
                r_rd_base   <= r_rd_base + c_hop;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            r_full       <= (w_state_nxt == S_LAUNCH);
            r_frame_done <= (w_state_nxt == S_RETIRE);
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign stft_full   = r_full;
    assign stft_datum  = r_datum;
    assign coeff_valid = r_coeff_valid;
    assign coeff_data  = r_coeff_data;
    assign coeff_idx   = r_coeff_idx;
    assign frame_done  = r_frame_done;
    assign frame_cnt   = r_frame_cnt;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_stft_frame_sched.sv
// ============================================================================
// Module      : tb_stft_frame_sched
// Description : Directed self-checking bench for stft_frame_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stft_frame_sched;

    localparam int FL = 2048;
    localparam int NC = 180;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        samp_valid;
    logic [15:0] samp_data;
    logic        samp_ready;
    logic        stft_full;
    logic [15:0] stft_datum;
    logic        stft_done = 1'b0;
    logic        stft_ready = 1'b0;
    logic [27:0] stft_coeff = '0;
    logic        coeff_valid;
    logic [27:0] coeff_data;
    logic [7:0]  coeff_idx;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        busy;
`ifdef STFT_SCHED_WDOG_EN
    logic        err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int fed = 0;
    int fed_base = 0;
    int feed_limit = 0;

    stft_frame_sched #(
        .DW(16), .CW(28), .FRAME_LEN(FL), .HOP(512), .DEPTH(4096), .NUM_COEFF(NC)
`ifdef STFT_SCHED_WDOG_EN
        , .WDOG_CYCLES(100)
`endif
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .samp_valid(samp_valid), .samp_data(samp_data), .samp_ready(samp_ready),
        .stft_full(stft_full), .stft_datum(stft_datum), .stft_done(stft_done),
        .stft_ready(stft_ready), .stft_coeff(stft_coeff),
        .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_idx(coeff_idx),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
`ifdef STFT_SCHED_WDOG_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Ramp source: sample n (since the last refill) carries value n.
    initial begin
        samp_valid = 1'b0;
        samp_data  = '0;
        forever begin
            @(negedge clk);
            if ((fed - fed_base) < feed_limit) begin
                samp_valid = 1'b1;
                samp_data  = 16'(fed - fed_base);
                if (samp_ready === 1'b1) fed++;
            end else begin
                samp_valid = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_launch(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (stft_full === 1'b1) got = 1'b1;
        end
    endtask

    task automatic stream_obs(input int base, input int done_at, input int en_off_at,
                              output int bad_k, output logic [15:0] bad_v,
                              output int fulls, output int rdy_lows);
        bad_k = -1; bad_v = '0; fulls = 0; rdy_lows = 0;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            if (stft_datum !== 16'(base + k) && bad_k < 0) begin
                bad_k = k; bad_v = stft_datum;
            end
            if (stft_full !== 1'b0) fulls++;
            if (samp_ready !== 1'b1) rdy_lows++;
            stft_done = (k == done_at);
            if (k == en_off_at) en = 1'b0;
        end
        stft_done = 1'b0;
    endtask

    task automatic send_done;
        @(negedge clk);
        stft_done = 1'b1;
        @(negedge clk);
        stft_done = 1'b0;
    endtask

    task automatic collect_run(input int first, input int last, output int bad);
        bad = 0;
        for (int i = first; i < last; i++) begin
            stft_ready = 1'b1;
            stft_coeff = 28'(i * 3);
            @(negedge clk);
            if ({coeff_valid, coeff_idx, coeff_data} !== {1'b1, 8'(i), 28'(i * 3)}) bad++;
            stft_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (samp_ready !== 1'b0) begin n_bad++; $display("FAIL reset_samp_ready: got %b want 0", samp_ready); end
        n_cmp++; if (stft_full !== 1'b0) begin n_bad++; $display("FAIL reset_stft_full: got %b want 0", stft_full); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (coeff_valid !== 1'b0) begin n_bad++; $display("FAIL reset_coeff_valid: got %b want 0", coeff_valid); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (stft_datum !== 16'd0) begin n_bad++; $display("FAIL reset_stft_datum: got %0d want 0", stft_datum); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (samp_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_samp_ready: got %b want 1", samp_ready); end
    endtask

    task automatic test_fill;
        bit got; int bk, fu, rl; logic [15:0] bv;
        en = 1'b1;
        feed_limit = 2048;
        wait_launch(3000, got);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL fill_launch: got %b want 1", got); end
        stream_obs(0, -1, -1, bk, bv, fu, rl);
        n_cmp++; if (bk != -1) begin n_bad++; $display("FAIL fill_stream: k=%0d got %0d want %0d", bk, bv, bk); end
        n_cmp++; if (fu != 0) begin n_bad++; $display("FAIL fill_single_pulse: extra pulses %0d want 0", fu); end
        n_cmp++; if (rl != 0) begin n_bad++; $display("FAIL fill_samp_ready: low cycles %0d want 0", rl); end
    endtask

    task automatic test_collect;
        send_done();
        for (int i = 0; i < NC; i++) begin
            stft_ready = 1'b1;
            stft_coeff = 28'(i * 3);
            @(negedge clk);
            n_cmp++;
            if ({coeff_valid, coeff_idx, coeff_data} !== {1'b1, 8'(i), 28'(i * 3)}) begin
                n_bad++;
                $display("FAIL collect_coeff: v=%b idx=%0d data=%0d want v=1 idx=%0d data=%0d",
                         coeff_valid, coeff_idx, coeff_data, i, i * 3);
            end
            if (i == NC - 1) begin
                n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL collect_frame_done: got %b want 1", frame_done); end
            end
            stft_ready = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL collect_frame_cnt: got %0d want 1", frame_cnt); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL collect_frame_done_pulse: got %b want 0", frame_done); end
    endtask

    task automatic test_overlap;
        bit got; int bk, fu, rl, nv, bad; logic [15:0] bv; logic [7:0] idx0; logic [27:0] d0;
        feed_limit = 3000;
        wait_launch(2000, got);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL overlap_launch: got %b want 1", got); end
        stream_obs(512, 100, 1000, bk, bv, fu, rl);
        n_cmp++; if (bk != -1) begin n_bad++; $display("FAIL overlap_stream: k=%0d got %0d want %0d", bk, bv, 512 + bk); end
        // Done was pulsed mid-stream; a strobe now must not be collected.
        repeat (2) @(negedge clk);
        stft_ready = 1'b1;
        stft_coeff = 28'hABC;
        @(negedge clk);
        n_cmp++; if (coeff_valid !== 1'b0) begin n_bad++; $display("FAIL stream_done_ignored: coeff_valid %b want 0", coeff_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wait_done_busy: got %b want 1", busy); end
        stft_ready = 1'b0;
        @(negedge clk);
        send_done();
        stft_ready = 1'b1;
        stft_coeff = 28'd777;
        nv = 0; idx0 = '0; d0 = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (coeff_valid === 1'b1) nv++;
            if (c == 0) begin idx0 = coeff_idx; d0 = coeff_data; end
        end
        stft_ready = 1'b0;
        @(negedge clk);
        if (coeff_valid === 1'b1) nv++;
        n_cmp++; if (nv != 1) begin n_bad++; $display("FAIL held_ready_count: got %0d want 1", nv); end
        n_cmp++; if ({idx0, d0} !== {8'd0, 28'd777}) begin n_bad++; $display("FAIL held_ready_coeff: idx=%0d data=%0d want idx=0 data=777", idx0, d0); end
        collect_run(1, NC, bad);
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL overlap_collect: bad coeffs %0d want 0", bad); end
        n_cmp++; if (frame_cnt !== 16'd2) begin n_bad++; $display("FAIL overlap_frame_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_launch_gate;
        bit got; int bk, fu, rl; logic [15:0] bv;
        feed_limit = 3071;
        for (int c = 0; c < 1000 && (fed - fed_base) < 3071; c++) @(negedge clk);
        en = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL gate_threshold: busy %b want 0 at pending 2047", busy); end
        en = 1'b0;
        feed_limit = 3100;
        for (int c = 0; c < 1000 && (fed - fed_base) < 3100; c++) @(negedge clk);
        repeat (30) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL gate_en_low: busy %b want 0", busy); end
        en = 1'b1;
        feed_limit = 1000000;
        wait_launch(10, got);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL gate_launch: got %b want 1", got); end
        stream_obs(1024, -1, -1, bk, bv, fu, rl);
        n_cmp++; if (bk != -1) begin n_bad++; $display("FAIL frame3_stream: k=%0d got %0d want %0d", bk, bv, 1024 + bk); end
    endtask

    task automatic test_backpressure;
        bit got; int bk, fu, rl, bad; logic [15:0] bv;
        for (int c = 0; c < 6000 && samp_ready !== 1'b0; c++) @(negedge clk);
        n_cmp++; if ((fed - fed_base) != 5120) begin n_bad++; $display("FAIL bp_stop_point: accepted %0d want 5120", fed - fed_base); end
        repeat (20) @(negedge clk);
        n_cmp++; if (samp_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold: samp_ready %b want 0", samp_ready); end
        n_cmp++; if ((fed - fed_base) != 5120) begin n_bad++; $display("FAIL bp_no_accept: accepted %0d want 5120", fed - fed_base); end
        send_done();
        collect_run(0, NC, bad);
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_collect: bad coeffs %0d want 0", bad); end
        n_cmp++; if (frame_cnt !== 16'd3) begin n_bad++; $display("FAIL bp_frame_cnt: got %0d want 3", frame_cnt); end
        wait_launch(10, got);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL bp_relaunch: got %b want 1", got); end
        stream_obs(1536, -1, -1, bk, bv, fu, rl);
        n_cmp++; if (bk != -1) begin n_bad++; $display("FAIL bp_stream_intact: k=%0d got %0d want %0d", bk, bv, 16'(1536 + bk)); end
    endtask

    task automatic test_reset_mid_collect;
        bit got; int bk, fu, rl, bad; logic [15:0] bv;
        send_done();
        collect_run(0, 50, bad);
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL pre_reset_collect: bad coeffs %0d want 0", bad); end
        feed_limit = 0;
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL abort_frame_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (coeff_idx !== 8'd0) begin n_bad++; $display("FAIL abort_coeff_idx: got %0d want 0", coeff_idx); end
        n_cmp++; if (stft_datum !== 16'd0) begin n_bad++; $display("FAIL abort_stft_datum: got %0d want 0", stft_datum); end
        n_cmp++; if (samp_ready !== 1'b0) begin n_bad++; $display("FAIL abort_samp_ready: got %b want 0", samp_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fed_base = fed;
        feed_limit = 2048;
        wait_launch(3000, got);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL refill_launch: got %b want 1", got); end
        stream_obs(0, -1, -1, bk, bv, fu, rl);
        n_cmp++; if (bk != -1) begin n_bad++; $display("FAIL refill_stream: k=%0d got %0d want %0d", bk, bv, bk); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL refill_frame_cnt0: got %0d want 0", frame_cnt); end
        send_done();
        collect_run(0, NC, bad);
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL refill_collect: bad coeffs %0d want 0", bad); end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL refill_frame_cnt1: got %0d want 1", frame_cnt); end
    endtask

`ifdef STFT_SCHED_WDOG_EN
    task automatic test_wdog;
        bit got; int bk, fu, rl, c, nv; logic [15:0] bv;
        feed_limit = 2560;
        wait_launch(1000, got);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL wdog_launch: got %b want 1", got); end
        stream_obs(512, -1, -1, bk, bv, fu, rl);
        c = 0; nv = 0;
        for (int i = 1; i <= 300 && c == 0; i++) begin
            @(negedge clk);
            if (coeff_valid === 1'b1) nv++;
            if (frame_done === 1'b1) c = i;
        end
        n_cmp++; if (c != 101) begin n_bad++; $display("FAIL wdog_timing: frame_done at %0d want 101", c); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL wdog_err: got %b want 1", err); end
        n_cmp++; if (nv != 0) begin n_bad++; $display("FAIL wdog_no_coeff: got %0d want 0", nv); end
        @(negedge clk);
        n_cmp++; if (frame_cnt !== 16'd2) begin n_bad++; $display("FAIL wdog_frame_cnt: got %0d want 2", frame_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_collect();
        test_overlap();
        test_launch_gate();
        test_backpressure();
        test_reset_mid_collect();
`ifdef STFT_SCHED_WDOG_EN
        test_wdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
